// File: rtl/mem_access_unit_if.sv
// Bundle of the request/response handshake and the datamem port of mem_access_unit.
// slave is the unit's view; master is the CPU-plus-datamem side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              we_DM;
    logic [ADDR_W-1:0] addrDM;
    logic [DATA_W-1:0] dataDM;
    logic [DATA_W-1:0] outDM;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, outDM,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, we_DM, addrDM, dataDM
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, outDM,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, we_DM, addrDM, dataDM
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and datamem: one request at a time,
// glitch-free write timing, fixed read latency. Define MAU_FWD_EN for last-store forwarding.
module mem_access_unit #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 2,
    parameter int WR_HOLD   = 1
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);
    localparam int              MAX_CNT = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
    localparam int              CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, WRITE, READ, RESP} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic addr_err;
    logic wr_done;

    assign addr_err = ({1'b0, bus.req_addr} >= DEPTH_C);
    assign wr_done  = (state_q == WRITE) && (cnt_q == '0);

`ifdef MAU_FWD_EN
    logic              fwd_vld_q;
    logic [ADDR_W-1:0] fwd_addr_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic              fwd_hit;

    assign fwd_hit = fwd_vld_q && (fwd_addr_q == bus.req_addr);

    // Address/data of the store being completed are exactly what sits on the datamem port.
    always_ff @(posedge clk) begin
        if (wr_done) begin
            fwd_addr_q <= addr_q;
            fwd_data_q <= data_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef MAU_FWD_EN
            fwd_vld_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_q <= 1'b0;
                        if (addr_err) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (bus.req_we) begin
                            state_q <= SETUP;
                            addr_q  <= bus.req_addr;
                            data_q  <= bus.req_wdata;
`ifdef MAU_FWD_EN
                        end else if (fwd_hit) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= fwd_data_q;
`endif
                        end else begin
                            state_q <= READ;
                            addr_q  <= bus.req_addr;
                            cnt_q   <= CNT_W'(RD_LAT - 1);
                        end
                    end
                end
                SETUP: begin
                    state_q <= WRITE;
                    we_q    <= 1'b1;
                    cnt_q   <= CNT_W'(WR_HOLD - 1);
                end
                WRITE: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
`ifdef MAU_FWD_EN
                        fwd_vld_q   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                READ: begin
                    // addrDM has been stable for RD_LAT cycles on this edge.
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= bus.outDM;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.we_DM     = we_q;
    assign bus.addrDM    = addr_q;
    assign bus.dataDM    = data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a datamem model and a transaction-level reference.
module tb_mem_access_unit;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 1024;
    localparam int RD_LAT    = 2;
    localparam int WR_HOLD   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
        .RD_LAT(RD_LAT), .WR_HOLD(WR_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // datamem: write on the clock edge while we_DM is high, combinational read
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    always @(posedge clk) begin
        if (bus.we_DM && (bus.addrDM < ADDR_W'(MEM_DEPTH)))
            mem[bus.addrDM[9:0]] <= bus.dataDM;
    end
    assign bus.outDM = (bus.addrDM < ADDR_W'(MEM_DEPTH)) ? mem[bus.addrDM[9:0]] : '0;

    // reference model state
    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
    logic              fwd_v;
    logic [ADDR_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_d;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called just after a negedge with the unit idle; returns just after a negedge, idle.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input bit keep_valid);
        logic [ADDR_W-1:0] addr_before;
        logic [DATA_W-1:0] data_before;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        int                exp_lat;
        bit                is_err, is_store, is_mem_load, got;
        int                lat, we_cnt;

        addr_before = bus.addrDM;
        data_before = bus.dataDM;
        is_err      = (addr >= ADDR_W'(MEM_DEPTH));
        is_store    = !is_err && we;
        is_mem_load = !is_err && !we;
        exp_err     = is_err;
        exp_rdata   = '0;
        if (is_err) begin
            exp_lat = 1;
        end else if (we) begin
            exp_lat = WR_HOLD + 2;
        end else begin
            exp_lat   = RD_LAT + 1;
            exp_rdata = ref_mem[addr[9:0]];
`ifdef MAU_FWD_EN
            if (fwd_v && fwd_a == addr) begin
                exp_lat     = 1;
                exp_rdata   = fwd_d;
                is_mem_load = 0;
            end
`endif
        end

        chk_eq("ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = keep_valid;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_wdata = DATA_W'($urandom);

        got = 0; lat = 0; we_cnt = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1;
                lat = k;
            end else begin
                chk_eq("busy_ready", bus.req_ready, 0);
                if (bus.we_DM) begin
                    we_cnt++;
                    chk_eq("wr_addr_stable", bus.addrDM, addr);
                    chk_eq("wr_data_stable", bus.dataDM, wdata);
                end
                if (is_store && k == 1) begin
                    chk_eq("setup_we", bus.we_DM, 0);
                    chk_eq("setup_addr", bus.addrDM, addr);
                    chk_eq("setup_data", bus.dataDM, wdata);
                end
                if (is_mem_load) begin
                    chk_eq("rd_addr", bus.addrDM, addr);
                    chk_eq("rd_we", bus.we_DM, 0);
                end
            end
        end
        chk_eq("rsp_timeout", got, 1);
        chk_eq("rsp_latency", lat, exp_lat);
        chk_eq("rsp_err", bus.rsp_err, exp_err);
        chk_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk_eq("rsp_we_low", bus.we_DM, 0);
        chk_eq("we_cycles", we_cnt, is_store ? WR_HOLD : 0);
        if (is_store) begin
            chk_eq("hold_addr", bus.addrDM, addr);
            chk_eq("hold_data", bus.dataDM, wdata);
        end else if (!is_mem_load) begin
            chk_eq("untouched_addr", bus.addrDM, addr_before);
            chk_eq("untouched_data", bus.dataDM, data_before);
        end

        if (is_store) begin
            ref_mem[addr[9:0]] = wdata;
            fwd_v = 1'b1;
            fwd_a = addr;
            fwd_d = wdata;
        end

        @(negedge clk);
        chk_eq("rsp_one_cycle", bus.rsp_valid, 0);
        chk_eq("ready_after", bus.req_ready, 1);
        chk_eq("rdata_hold", bus.rsp_rdata, exp_rdata);
        chk_eq("err_hold", bus.rsp_err, exp_err);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                pick;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            d          = DATA_W'($urandom);
            mem[i]     = d;
            ref_mem[i] = d;
        end
        fwd_v = 1'b0;
        fwd_a = '0;
        fwd_d = '0;

        repeat (2) @(negedge clk);
        chk_eq("rst_ready", bus.req_ready, 1);
        chk_eq("rst_rsp_valid", bus.rsp_valid, 0);
        chk_eq("rst_rsp_err", bus.rsp_err, 0);
        chk_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk_eq("rst_we", bus.we_DM, 0);
        chk_eq("rst_addr", bus.addrDM, 0);
        chk_eq("rst_data", bus.dataDM, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed: store/load pair, out-of-range, held req_valid
        do_req(1'b1, 16'h0000, 16'h1DFE, 1'b0);
        do_req(1'b0, 16'h0000, 16'h0000, 1'b0);
        do_req(1'b0, 16'h0400, 16'h0000, 1'b0);
        do_req(1'b1, 16'h0001, 16'h7777, 1'b1);
        do_req(1'b0, 16'h0001, 16'h0000, 1'b1);

        // reset in the middle of a store
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0003;
        bus.req_wdata = 16'hBEEF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("midwr_we_high", bus.we_DM, 1);
        #2 rst = 1'b1;
        #1;
        chk_eq("async_we_low", bus.we_DM, 0);
        chk_eq("async_ready", bus.req_ready, 1);
        chk_eq("async_rsp_valid", bus.rsp_valid, 0);
        chk_eq("async_addr", bus.addrDM, 0);
        chk_eq("async_data", bus.dataDM, 0);
        chk_eq("async_rdata", bus.rsp_rdata, 0);
        chk_eq("async_err", bus.rsp_err, 0);
        fwd_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_eq("no_rsp_after_abort", bus.rsp_valid, 0);
        end
        do_req(1'b1, 16'h0003, 16'h5A5A, 1'b0);
        do_req(1'b0, 16'h0003, 16'h0000, 1'b0);

        // forwarding candidate pair
        do_req(1'b1, 16'h0002, 16'hA001, 1'b0);
        do_req(1'b0, 16'h0002, 16'h0000, 1'b0);
        do_req(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        do_req(1'b0, 16'h0002, 16'h0000, 1'b0);

        // randomized traffic over a small address window plus range edges
        for (int n = 0; n < 200; n++) begin
            pick = $urandom_range(0, 11);
            if (pick < 8)       a = ADDR_W'(pick);
            else if (pick == 8) a = ADDR_W'(MEM_DEPTH - 1);
            else if (pick == 9) a = ADDR_W'(MEM_DEPTH);
            else                a = ADDR_W'($urandom_range(MEM_DEPTH, 65535));
            do_req(1'($urandom), a, DATA_W'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
